// File: rtl/acc_regfile_16_pkg.sv
// Shared constants for the write-back destination stage and the control unit
// that drives it.
//   WIDTH  : data width of accumulator, registers and write data
//   NREGS  : number of general registers
//   AW     : register address width
//   WCNT_W : width of the committed-register-write counter
//   WSEL_* : encodings of the write destination select
package acc_regfile_16_pkg;

  localparam int WIDTH  = 16;
  localparam int NREGS  = 8;
  localparam int AW     = 3;
  localparam int WCNT_W = 8;

  localparam logic [1:0] WSEL_NONE = 2'd0;
  localparam logic [1:0] WSEL_ACC  = 2'd1;
  localparam logic [1:0] WSEL_REG  = 2'd2;
  localparam logic [1:0] WSEL_BOTH = 2'd3;

endpackage

// File: rtl/acc_regfile_16_regfile_8x16.sv
// regfile_8x16: general register array.
//   clk, rst            : clock, async active-high reset (clears every entry)
//   we_i/waddr_i/wdata_i: synchronous write port
//   raddr_a_i/rd_a_o    : async read port A
//   raddr_b_i/rd_b_o    : async read port B
//   rd_w_o              : async read of the write address, used by swap to
//                         fetch the old register value on the same edge
module regfile_8x16
  import acc_regfile_16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rd_a_o,
  output logic [WIDTH-1:0] rd_b_o,
  output logic [WIDTH-1:0] rd_w_o
);

  logic [WIDTH-1:0] mem_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see pre-edge contents; there is deliberately no write forwarding.
  assign rd_a_o = mem_q[raddr_a_i];
  assign rd_b_o = mem_q[raddr_b_i];
  assign rd_w_o = mem_q[waddr_i];

endmodule

// File: rtl/acc_regfile_16.sv
// acc_regfile_16: write-back destination stage.
//   clk, rst        : clock, async active-high reset
//   wd              : write data from the write-back select mux
//   wsel            : destination (none / acc / reg[waddr] / both)
//   waddr           : destination register for wsel reg/both and for swap
//   swap            : exchange acc with reg[waddr]; overrides wsel, ignores wd
//   raddr_a/raddr_b : read port indices
//   rd_a/rd_b       : register operands, combinational
//   acc             : accumulator, registered
//   zf/nf           : zero/negative flags of the last value written to acc
//   wcount          : count of register-file writes, wraps at 2^8
module acc_regfile_16
  import acc_regfile_16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  wd,
  input  logic [1:0]        wsel,
  input  logic [AW-1:0]     waddr,
  input  logic              swap,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [WIDTH-1:0]  rd_a,
  output logic [WIDTH-1:0]  rd_b,
  output logic [WIDTH-1:0]  acc,
  output logic              zf,
  output logic              nf,
  output logic [WCNT_W-1:0] wcount
);

  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              zf_q, zf_d;
  logic              nf_q, nf_d;
  logic [WCNT_W-1:0] wcount_q, wcount_d;
  logic              acc_we;
  logic              rf_we;
  logic [WIDTH-1:0]  rf_wdata;
  logic [WIDTH-1:0]  rf_rd_w;

  regfile_8x16 u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (rf_we),
    .waddr_i   (waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (raddr_a),
    .raddr_b_i (raddr_b),
    .rd_a_o    (rd_a),
    .rd_b_o    (rd_b),
    .rd_w_o    (rf_rd_w)
  );

  always_comb begin
    acc_we   = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = wd;
    acc_d    = acc_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    wcount_d = wcount_q;

    if (swap) begin
      acc_we   = 1'b1;
      acc_d    = rf_rd_w;
      rf_we    = 1'b1;
      rf_wdata = acc_q;
    end else begin
      case (wsel)
        WSEL_ACC: begin
          acc_we = 1'b1;
          acc_d  = wd;
        end
        WSEL_REG: begin
          rf_we = 1'b1;
        end
        WSEL_BOTH: begin
          acc_we = 1'b1;
          acc_d  = wd;
          rf_we  = 1'b1;
        end
        default: ;
      endcase
    end

    // Flags track the value being written, not the current acc.
    if (acc_we) begin
      zf_d = (acc_d == '0);
      nf_d = acc_d[WIDTH-1];
    end

    if (rf_we) wcount_d = wcount_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      zf_q     <= 1'b1;
      nf_q     <= 1'b0;
      wcount_q <= '0;
    end else begin
      acc_q    <= acc_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      wcount_q <= wcount_d;
    end
  end

  assign acc    = acc_q;
  assign zf     = zf_q;
  assign nf     = nf_q;
  assign wcount = wcount_q;

endmodule

// File: tb/tb_acc_regfile_16.sv
module tb_acc_regfile_16;

  logic        clk;
  logic        rst;
  logic [15:0] wd;
  logic [1:0]  wsel;
  logic [2:0]  waddr;
  logic        swap;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic [15:0] acc;
  logic        zf;
  logic        nf;
  logic [7:0]  wcount;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int unsigned m_regs [8];
  int unsigned m_acc;
  bit          m_zf;
  bit          m_nf;
  int unsigned m_wcount;

  acc_regfile_16 dut (
    .clk     (clk),
    .rst     (rst),
    .wd      (wd),
    .wsel    (wsel),
    .waddr   (waddr),
    .swap    (swap),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rd_a    (rd_a),
    .rd_b    (rd_b),
    .acc     (acc),
    .zf      (zf),
    .nf      (nf),
    .wcount  (wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_acc    = 0;
    m_zf     = 1;
    m_nf     = 0;
    m_wcount = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ":acc"},    acc,    m_acc);
    check({tag, ":zf"},     zf,     m_zf);
    check({tag, ":nf"},     nf,     m_nf);
    check({tag, ":wcount"}, wcount, m_wcount);
    check({tag, ":rd_a"},   rd_a,   m_regs[raddr_a]);
    check({tag, ":rd_b"},   rd_b,   m_regs[raddr_b]);
  endtask

  // One clock edge: the model applies the rules to the pre-edge state,
  // then the DUT is compared 1 time unit after the edge.
  task automatic cycle(input string tag);
    int unsigned old_acc = m_acc;
    int unsigned old_reg = m_regs[waddr];
    bit acc_written = 0;
    bit reg_written = 0;
    if (swap) begin
      m_acc         = old_reg;
      m_regs[waddr] = old_acc;
      acc_written   = 1;
      reg_written   = 1;
    end else begin
      if (wsel == 1 || wsel == 3) begin
        m_acc = wd;
        acc_written = 1;
      end
      if (wsel == 2 || wsel == 3) begin
        m_regs[waddr] = wd;
        reg_written = 1;
      end
    end
    if (acc_written) begin
      m_zf = (m_acc == 0);
      m_nf = (m_acc >= 32768);
    end
    if (reg_written) m_wcount = (m_wcount + 1) % 256;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [1:0] s, input logic [2:0] a, input logic [15:0] d, input logic sw);
    wsel  = s;
    waddr = a;
    wd    = d;
    swap  = sw;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'd0, 3'd0, 16'h0, 1'b0);
    raddr_a = 3'd0;
    raddr_b = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    rst = 1'b0;

    // 1: reset in the middle of a pending write
    drive(2'd3, 3'd5, 16'h1234, 1'b0);
    raddr_a = 3'd5;
    cycle("pre1");
    drive(2'd3, 3'd5, 16'h4321, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
    drive(2'd3, 3'd5, 16'h1234, 1'b0);
    cycle("post_rst");
    check("t1_acc", acc, 16'h1234);
    check("t1_rd_a", rd_a, 16'h1234);
    check("t1_wcount", wcount, 1);

    // 2: flags
    drive(2'd1, 3'd0, 16'h8000, 1'b0);
    cycle("acc8000");
    check("t2_nf", nf, 1);
    check("t2_zf", zf, 0);
    drive(2'd1, 3'd0, 16'h0000, 1'b0);
    cycle("acc0");
    check("t2_zf0", zf, 1);
    drive(2'd2, 3'd1, 16'hFFFF, 1'b0);
    cycle("reg_ffff");
    check("t2_zf_hold", zf, 1);
    check("t2_nf_hold", nf, 0);

    // 3: swap overrides wsel and ignores wd
    drive(2'd1, 3'd0, 16'h00AA, 1'b0);
    cycle("acc_aa");
    drive(2'd2, 3'd3, 16'h0055, 1'b0);
    cycle("reg3_55");
    raddr_a = 3'd3;
    drive(2'd1, 3'd3, 16'h7777, 1'b1);
    cycle("swap");
    check("t3_acc", acc, 16'h0055);
    check("t3_reg3", rd_a, 16'h00AA);
    drive(2'd0, 3'd0, 16'h0, 1'b0);

    // 4: read during write returns old value
    drive(2'd2, 3'd2, 16'h0011, 1'b0);
    cycle("reg2_11");
    raddr_a = 3'd2;
    drive(2'd2, 3'd2, 16'h0022, 1'b0);
    #1;
    check("t4_before", rd_a, 16'h0011);
    cycle("reg2_22");
    check("t4_after", rd_a, 16'h0022);

    // 5: dual read sweep
    for (int i = 0; i < 8; i++) begin
      drive(2'd2, 3'(i), 16'(8 * i), 1'b0);
      cycle("fill");
    end
    drive(2'd0, 3'd0, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      raddr_b = 3'(7 - i);
      #1;
      check("t5_rd_a", rd_a, 8 * i);
      check("t5_rd_b", rd_b, 8 * (7 - i));
    end

    // 6: wcount wrap, acc-only writes do not count
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(2'd2, 3'($urandom_range(0, 7)), 16'($urandom), 1'b0);
      cycle("wrap_reg");
      if (i % 3 == 0) begin
        drive(2'd1, 3'd0, 16'($urandom), 1'b0);
        cycle("wrap_acc");
      end
      if (i == 99) check("t6_mid", wcount, 100);
    end
    check("t6_wrap", wcount, 0);

    // Random traffic with occasional async resets
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 5))
        0: d = 16'h0000;
        1: d = 16'h8000;
        default: d = 16'($urandom);
      endcase
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), d,
            ($urandom_range(0, 3) == 0));
      raddr_a = 3'($urandom_range(0, 7));
      raddr_b = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rnd_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        cycle("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
